// File: rtl/vend_pkg.sv
// Shared definitions for the coin front end and the vending FSM.
package vend_pkg;

  // Per-channel debounce state; the encoding is visible to the FSM team.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARM     = 2'b01,
    HELD    = 2'b10,
    RELEASE = 2'b11
  } chan_state_e;

  // Coin values in cents, consumed by the downstream vending FSM.
  localparam int unsigned NICKEL = 5;
  localparam int unsigned DIME   = 10;

  // A channel counts as "coin present" from acceptance until the release is confirmed.
  function automatic logic is_engaged(input chan_state_e s);
    return (s == HELD) || (s == RELEASE);
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin chute: 2-flop synchronizer, press/release debounce FSM and sample counter.
// o_req is a single-cycle strobe on the ARM->HELD transition; o_held is high in HELD/RELEASE.
module coin_debounce
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4  // must be >= 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_req,
  output logic o_held
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_meta;
  logic             r_sync;
  chan_state_e      r_state;
  chan_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == CNT_MAX);

  // Bring the raw sensor level into the clock domain; only r_sync is used downstream.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
    end
  end

  // Debounce state and stable-sample counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: count consecutive stable samples; any opposite sample aborts the count.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_req       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_sync) begin
          w_state_nxt = ARM;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      ARM: begin
        if (!r_sync) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_at_max) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          o_req       = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!r_sync) begin
          w_state_nxt = RELEASE;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      RELEASE: begin
        // A high sample here is release bounce: fall back to HELD without a new request.
        if (r_sync) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (w_at_max) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_held = is_engaged(r_state);

endmodule

// File: rtl/coin_pulse_conditioner.sv
// Coin front end: two debounced chutes, nickel-priority arbiter producing
// mutually exclusive one-cycle D/N pulses, and a registered jam flag.
module coin_pulse_conditioner
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Dime_raw,
  input  logic Nickel_raw,
  output logic D,
  output logic N,
  output logic Jam
);

  logic w_req_d, w_req_n;
  logic w_held_d, w_held_n;
  logic w_want_d, w_want_n;
  logic w_gnt_d, w_gnt_n;
  logic r_pend_d, r_pend_n;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dime (
    .i_clk  (Clock),
    .i_rst  (Reset),
    .i_raw  (Dime_raw),
    .o_req  (w_req_d),
    .o_held (w_held_d)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nickel (
    .i_clk  (Clock),
    .i_rst  (Reset),
    .i_raw  (Nickel_raw),
    .o_req  (w_req_n),
    .o_held (w_held_n)
  );

  // Nickel wins a tie; the dime waits one cycle in its pending flag.
  assign w_want_d = r_pend_d | w_req_d;
  assign w_want_n = r_pend_n | w_req_n;
  assign w_gnt_n  = w_want_n;
  assign w_gnt_d  = w_want_d & ~w_want_n;

  // Pending flags hold an ungranted request; outputs are the registered grants.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_pend_d <= 1'b0;
      r_pend_n <= 1'b0;
      D        <= 1'b0;
      N        <= 1'b0;
      Jam      <= 1'b0;
    end else begin
      r_pend_d <= w_want_d & ~w_gnt_d;
      r_pend_n <= w_want_n & ~w_gnt_n;
      D        <= w_gnt_d;
      N        <= w_gnt_n;
      Jam      <= w_held_d & w_held_n;
    end
  end

endmodule
